// File: rtl/mips_cpu_pkg.sv
// Shared MIPS CPU definitions: multiply/divide operation codes and the
// R-type function codes used by the decoder and the HI/LO sequencer.
package mips_cpu_pkg;

   typedef enum logic [1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } muldiv_op_t;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

endpackage

// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide sequencer owning HI/LO: shift-add multiplier and
// restoring divider sharing one 64-bit working register and one adder.
module mips_cpu_muldiv
   import mips_cpu_pkg::*;
#(
   parameter int unsigned ITERATIONS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] mt_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned SUM_W  = WORD_W + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2
   } muldiv_state_t;

   muldiv_state_t state_q, state_d;
   muldiv_op_t    op_q, op_d;
   logic [WORD_W-1:0]   mag_a_q, mag_a_d;
   logic [WORD_W-1:0]   mag_b_q, mag_b_d;
   logic [2*WORD_W-1:0] work_q, work_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                prod_neg_q, prod_neg_d;
   logic                rem_neg_q, rem_neg_d;
   logic [WORD_W-1:0]   hi_d, lo_d;
   logic                busy_d, done_d;

   logic                is_div;
   logic                in_signed;
   logic [SUM_W-1:0]    add_x, add_y, add_s;
   logic                add_cin;
   logic [2*WORD_W-1:0] mul_step, div_step;
   logic [2*WORD_W-1:0] prod_fix;
   logic [WORD_W-1:0]   quot_fix, rem_fix, dividend;

   function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] x,
                                                    input logic sgn);
      return (sgn && x[WORD_W-1]) ? -x : x;
   endfunction

   assign is_div    = (op_q == DIV) || (op_q == DIVU);
   assign in_signed = (muldiv_op_t'(op) == MULT) || (muldiv_op_t'(op) == DIV);

   // Shared adder: accumulate multiplicand, or trial-subtract the divisor
   always_comb begin
      if (is_div) begin
         add_x   = {1'b0, work_q[2*WORD_W-1:WORD_W-1]};
         add_y   = ~{2'b00, mag_b_q};
         add_cin = 1'b1;
      end else begin
         add_x   = {2'b00, work_q[2*WORD_W-1:WORD_W]};
         add_y   = {2'b00, mag_a_q};
         add_cin = 1'b0;
      end
      add_s = add_x + add_y + SUM_W'(add_cin);
   end

   // One iteration of each algorithm; add_s[SUM_W-1] is the divide borrow
   always_comb begin
      mul_step = work_q[0] ? {add_s[WORD_W:0], work_q[WORD_W-1:1]}
                           : {1'b0, work_q[2*WORD_W-1:1]};
      div_step = add_s[SUM_W-1] ? {work_q[2*WORD_W-2:0], 1'b0}
                                : {add_s[WORD_W-1:0], work_q[WORD_W-2:0], 1'b1};
   end

   always_comb begin
      prod_fix = prod_neg_q ? -work_q : work_q;
      quot_fix = prod_neg_q ? -work_q[WORD_W-1:0] : work_q[WORD_W-1:0];
      rem_fix  = rem_neg_q ? -work_q[2*WORD_W-1:WORD_W] : work_q[2*WORD_W-1:WORD_W];
      dividend = rem_neg_q ? -mag_a_q : mag_a_q;
   end

   // Next-state and register update logic
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      mag_a_d    = mag_a_q;
      mag_b_d    = mag_b_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      prod_neg_d = prod_neg_q;
      rem_neg_d  = rem_neg_q;
      hi_d       = hi;
      lo_d       = lo;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (mthi) hi_d = mt_data;
            if (mtlo) lo_d = mt_data;
            if (start) begin
               op_d       = muldiv_op_t'(op);
               mag_a_d    = magnitude(op_a, in_signed);
               mag_b_d    = magnitude(op_b, in_signed);
               prod_neg_d = in_signed & (op_a[WORD_W-1] ^ op_b[WORD_W-1]);
               rem_neg_d  = in_signed & op_a[WORD_W-1];
               cnt_d      = '0;
               work_d     = '0;
               state_d    = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            // First RUN cycle seeds the working register from the magnitudes
            if (cnt_q == '0) begin
               work_d = is_div ? {{WORD_W{1'b0}}, mag_a_q} : {{WORD_W{1'b0}}, mag_b_q};
            end else begin
               work_d = is_div ? div_step : mul_step;
            end
            if (cnt_q == CNT_W'(ITERATIONS)) state_d = FIXUP;
         end
         FIXUP: begin
            if (is_div && (mag_b_q == '0)) begin
               hi_d = dividend;
               lo_d = '1;
            end else if (is_div) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[2*WORD_W-1:WORD_W];
               lo_d = prod_fix[WORD_W-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else if (clk_enable) begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= MULT;
         mag_a_q    <= '0;
         mag_b_q    <= '0;
         work_q     <= '0;
         cnt_q      <= '0;
         prod_neg_q <= 1'b0;
         rem_neg_q  <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (clk_enable) begin
         op_q       <= op_d;
         mag_a_q    <= mag_a_d;
         mag_b_q    <= mag_b_d;
         work_q     <= work_d;
         cnt_q      <= cnt_d;
         prod_neg_q <= prod_neg_d;
         rem_neg_q  <= rem_neg_d;
         hi         <= hi_d;
         lo         <= lo_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed, table-driven bench for mips_cpu_muldiv with hand-computed results
// and hand-written sequences for the MT, reset and clock-enable corner cases.
module tb_mips_cpu_muldiv;
   import mips_cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, clk_enable, start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] op_a, op_b, mt_data;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      muldiv_op_t  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   mips_cpu_muldiv dut (
      .clk        (clk),
      .reset      (reset),
      .clk_enable (clk_enable),
      .start      (start),
      .op         (op),
      .op_a       (op_a),
      .op_b       (op_b),
      .mthi       (mthi),
      .mtlo       (mtlo),
      .mt_data    (mt_data),
      .busy       (busy),
      .done       (done),
      .hi         (hi),
      .lo         (lo)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and follow it to done; clk_enable drops for gap_len
   // cycles starting gap_at cycles after the start edge.
   task automatic do_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input int gap_at, input int gap_len,
                        output int lat, output int busy_n, output logic held);
      logic [31:0] h0, l0;
      h0 = hi;
      l0 = lo;
      held = 1'b1;
      busy_n = 0;
      lat = -1;
      op = o;
      op_a = a;
      op_b = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      op = 2'($urandom);
      op_a = $urandom;
      op_b = $urandom;
      for (int j = 0; j < 80; j++) begin
         if (busy) busy_n++;
         if (done) begin
            lat = j;
            break;
         end
         if (hi !== h0 || lo !== l0) held = 1'b0;
         if (j == gap_at) clk_enable = 1'b0;
         if (j == gap_at + gap_len) clk_enable = 1'b1;
         tick();
      end
      clk_enable = 1'b1;
   endtask

   initial begin
      int lat, bn, tot;
      logic held, saw_done;
      logic [31:0] h0;

      vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
      vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
      vecs[6]  = '{MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[7]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8]  = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[9]  = '{DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      vecs[10] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[11] = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};

      reset = 1'b1;
      clk_enable = 1'b1;
      start = 1'b0;
      mthi = 1'b0;
      mtlo = 1'b0;
      op = 2'd0;
      op_a = '0;
      op_b = '0;
      mt_data = '0;
      repeat (2) tick();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      reset = 1'b0;
      tick();

      // Simultaneous MTHI/MTLO in IDLE
      mthi = 1'b1;
      mtlo = 1'b1;
      mt_data = 32'hCAFEF00D;
      tick();
      mthi = 1'b0;
      mtlo = 1'b0;
      check("mt_both_hi", hi, 32'hCAFEF00D);
      check("mt_both_lo", lo, 32'hCAFEF00D);

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, lat, bn, held);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd34);
         check($sformatf("v%0d_busy_cycles", i), 32'(bn), 32'd34);
         check($sformatf("v%0d_hold", i), 32'(held), 32'd1);
         check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
         check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
         tick();
         check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      end

      // start and mthi while busy are ignored
      op = MULTU;
      op_a = 32'd3;
      op_b = 32'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      h0 = hi;
      op = DIV;
      op_a = 32'd100;
      op_b = 32'd7;
      start = 1'b1;
      mthi = 1'b1;
      mt_data = 32'hAAAA5555;
      tick();
      start = 1'b0;
      mthi = 1'b0;
      check("busy_mthi_ignored", hi, h0);
      tot = 6;
      for (int j = 0; j < 60 && !done; j++) begin
         tick();
         tot++;
      end
      check("busy_start_latency", 32'(tot), 32'd34);
      check("busy_start_hi", hi, 32'h0);
      check("busy_start_lo", lo, 32'd12);
      tick();
      check("no_queued_op", 32'(busy), 32'd0);
      mtlo = 1'b1;
      mt_data = 32'h1234;
      tick();
      mtlo = 1'b0;
      check("mtlo_idle_lo", lo, 32'h1234);
      check("mtlo_idle_hi", hi, 32'h0);

      // MTHI landing in the same cycle as start, later overwritten
      op = MULTU;
      op_a = 32'd2;
      op_b = 32'd3;
      start = 1'b1;
      mthi = 1'b1;
      mt_data = 32'h5A5A5A5A;
      tick();
      start = 1'b0;
      mthi = 1'b0;
      check("mt_with_start_hi", hi, 32'h5A5A5A5A);
      check("mt_with_start_busy", 32'(busy), 32'd1);
      for (int j = 0; j < 60 && !done; j++) tick();
      check("mt_with_start_done", 32'(done), 32'd1);
      check("mt_with_start_rhi", hi, 32'h0);
      check("mt_with_start_rlo", lo, 32'd6);
      tick();

      // Asynchronous reset mid-operation
      op = MULTU;
      op_a = 32'hFFFFFFFF;
      op_b = 32'hFFFFFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      #3 reset = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      tick();
      reset = 1'b0;
      saw_done = 1'b0;
      for (int j = 0; j < 40; j++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      check("abort_no_done", 32'(saw_done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);

      // Clock enable held low for 5 cycles mid-RUN
      do_op(MULT, 32'hFFFFFFFD, 32'd7, 10, 5, lat, bn, held);
      check("ce_latency", 32'(lat), 32'd39);
      check("ce_busy_cycles", 32'(bn), 32'd39);
      check("ce_hi", hi, 32'hFFFFFFFF);
      check("ce_lo", lo, 32'hFFFFFFEB);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
